// File: rtl/proc_pkg.sv
// Shared definitions for the instruction feeder: word width, opcode and
// class encodings, the feeder state type and the instruction legality check.
package proc_pkg;

   localparam int INST_W = 10;

   // Opcodes carried in [3:0] of class-00 instructions.
   localparam logic [3:0] LOAD  = 4'd0;
   localparam logic [3:0] STORE = 4'd1;
   localparam logic [3:0] MOV   = 4'd2;
   localparam logic [3:0] CP    = 4'd3;
   localparam logic [3:0] ADD   = 4'd4;
   localparam logic [3:0] SUB   = 4'd5;
   localparam logic [3:0] ANDR  = 4'd6;
   localparam logic [3:0] ORR   = 4'd7;
   localparam logic [3:0] XORR  = 4'd8;
   localparam logic [3:0] NOTR  = 4'd9;
   localparam logic [3:0] ADDI  = 4'd10;
   localparam logic [3:0] SUBI  = 4'd11;

   // Instruction class in [9:8]; 2'b01 is unassigned.
   localparam logic [1:0] CLS_ALU = 2'b00;
   localparam logic [1:0] CLS_MEM = 2'b10;
   localparam logic [1:0] CLS_IMM = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   // A word is executable when its class is assigned and, for the
   // register class, its opcode lies within LOAD..SUBI.
   function automatic logic is_legal(input logic [INST_W-1:0] w);
      logic ok;
      ok = 1'b0;
      case (w[9:8])
         CLS_ALU: ok = (w[3:0] <= SUBI);
         CLS_MEM: ok = 1'b1;
         CLS_IMM: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Host/controller-facing signal bundle of the instruction feeder.
interface instr_feeder_if;
   import proc_pkg::*;

   logic              wr_en;
   logic [INST_W-1:0] wr_data;
   logic              IRin;
   logic              Clr;
   logic [INST_W-1:0] DATA;
   logic [1:0]        T;
   logic              full;
   logic              empty;
   logic              ovf;
   logic              illegal;
   logic              timeout;

   // Host and controller side: drives pushes and control strobes.
   modport master (
      output wr_en, wr_data, IRin, Clr,
      input  DATA, T, full, empty, ovf, illegal, timeout
   );

   // Feeder side.
   modport slave (
      input  wr_en, wr_data, IRin, Clr,
      output DATA, T, full, empty, ovf, illegal, timeout
   );

endinterface

// File: rtl/instr_fifo.sv
// Instruction FIFO: registered head (no fall-through), power-of-two depth,
// simultaneous push and pop allowed even when full.
module instr_fifo
   import proc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [INST_W-1:0] wr_data,
   output logic [INST_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic              last,
   output logic              drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   logic [INST_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign last    = (count == ONE_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign head    = mem[rd_ptr];

   // Storage write; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally at the power-of-two depth; occupancy tracks both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: queues host words and presents them to the controller,
// sequencing the timestep T through fetch and a 1..3 execute window.
module instr_feeder
   import proc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   instr_feeder_if.slave bus
);

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        t;
   logic [1:0]        t_nxt;
   logic [INST_W-1:0] ir;
   logic [INST_W-1:0] head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_last;
   logic              fifo_drop;
   logic              pop;
   logic              ir_load;
   logic              illegal_nxt;
   logic              timeout_nxt;
   logic              ovf_q;
   logic              illegal_q;
   logic              timeout_q;

   instr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (bus.wr_en),
      .pop     (pop),
      .wr_data (bus.wr_data),
      .head    (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .last    (fifo_last),
      .drop    (fifo_drop)
   );

   // Control state, timestep and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         t         <= 2'd0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         t         <= t_nxt;
         ovf_q     <= fifo_drop;
         illegal_q <= illegal_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   // Instruction register; only observed in EXEC, so it carries no reset.
   always_ff @(posedge clk) begin
      if (ir_load) ir <= head;
   end

   // Next-state, timestep and pop decisions.
   always_comb begin
      state_nxt   = state;
      t_nxt       = t;
      pop         = 1'b0;
      ir_load     = 1'b0;
      illegal_nxt = 1'b0;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) state_nxt = FETCH;
         end
         FETCH: begin
            if (bus.IRin) begin
               pop = 1'b1;
               if (is_legal(head)) begin
                  ir_load   = 1'b1;
                  t_nxt     = 2'd1;
                  state_nxt = EXEC;
               end else begin
                  // Bad word is dropped; stay fetching if anything remains.
                  illegal_nxt = 1'b1;
                  if (fifo_last && !bus.wr_en) state_nxt = IDLE;
               end
            end
         end
         EXEC: begin
            if (bus.Clr || (t == 2'd3)) begin
               t_nxt       = 2'd0;
               timeout_nxt = !bus.Clr;
               state_nxt   = fifo_empty ? IDLE : FETCH;
            end else begin
               t_nxt = t + 2'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            t_nxt     = 2'd0;
         end
      endcase
   end

   assign bus.DATA    = (state == EXEC) ? ir : (fifo_empty ? '0 : head);
   assign bus.T       = t;
   assign bus.full    = fifo_full;
   assign bus.empty   = fifo_empty;
   assign bus.ovf     = ovf_q;
   assign bus.illegal = illegal_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder with a scoreboard of expected executed words.
module tb_instr_feeder;
   import proc_pkg::*;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   n;
   logic [INST_W-1:0] exp_q [$];

   instr_feeder_if bus ();

   instr_feeder #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_exec(input string tag);
      logic [INST_W-1:0] e;
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL %s: observed %0h expected <none queued>", tag, bus.DATA);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk(tag, 32'(bus.DATA), 32'(e));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [INST_W-1:0] w, input bit will_exec);
      bus.wr_en   = 1'b1;
      bus.wr_data = w;
      if (will_exec) exp_q.push_back(w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wr_en = 1'b0; bus.wr_data = '0; bus.IRin = 1'b0; bus.Clr = 1'b0;
      rst = 1'b1;
      #2;
      chk("rst_T", bus.T, 0);
      chk("rst_DATA", bus.DATA, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_illegal", bus.illegal, 0);
      chk("rst_timeout", bus.timeout, 0);
      tick(); rst = 1'b0; tick();

      // IRin and Clr while idle and empty do nothing
      bus.IRin = 1'b1; bus.Clr = 1'b1; tick(); bus.IRin = 1'b0; bus.Clr = 1'b0;
      chk("idle_ign_T", bus.T, 0);
      chk("idle_ign_empty", bus.empty, 1);

      // single instruction, Clr at T=1
      push(10'h040, 1); tick(); bus.wr_en = 1'b0;
      chk("s1_head", bus.DATA, 10'h040);
      chk("s1_empty", bus.empty, 0);
      tick();
      chk("s1_fetch_T", bus.T, 0);
      bus.IRin = 1'b1; tick(); bus.IRin = 1'b0;
      chk("s1_T1", bus.T, 1);
      chk_exec("s1_exec_data");
      bus.Clr = 1'b1; tick(); bus.Clr = 1'b0;
      chk("s1_T0", bus.T, 0);
      chk("s1_empty_after", bus.empty, 1);
      chk("s1_data0", bus.DATA, 0);

      // two instructions, Clr at T=3 each
      push(10'h012, 1); tick(); push(10'h245, 1); tick(); bus.wr_en = 1'b0;
      chk("s2_head1", bus.DATA, 10'h012);
      bus.IRin = 1'b1; tick(); bus.IRin = 1'b0;
      chk("s2_T1a", bus.T, 1);
      chk_exec("s2_data1");
      tick(); chk("s2_T2a", bus.T, 2); chk("s2_hold1", bus.DATA, 10'h012);
      tick(); chk("s2_T3a", bus.T, 3);
      bus.Clr = 1'b1; tick(); bus.Clr = 1'b0;
      chk("s2_T0a", bus.T, 0);
      chk("s2_head2", bus.DATA, 10'h245);
      bus.IRin = 1'b1; tick(); bus.IRin = 1'b0;
      chk("s2_T1b", bus.T, 1);
      chk_exec("s2_data2");
      tick(); chk("s2_T2b", bus.T, 2);
      tick(); chk("s2_T3b", bus.T, 3);
      bus.Clr = 1'b1; tick(); bus.Clr = 1'b0;
      chk("s2_T0b", bus.T, 0);
      chk("s2_empty", bus.empty, 1);
      chk("s2_no_timeout", bus.timeout, 0);

      // fill, overflow, push+pop while full, then drain
      for (int i = 0; i < DEPTH; i++) begin
         push(10'h200 + 10'(i), 1); tick();
      end
      chk("s3_full", bus.full, 1);
      chk("s3_ovf_pre", bus.ovf, 0);
      push(10'h3FF, 0); tick(); bus.wr_en = 1'b0;
      chk("s3_ovf", bus.ovf, 1);
      chk("s3_full_kept", bus.full, 1);
      tick();
      chk("s3_ovf_once", bus.ovf, 0);
      push(10'h2AA, 1); bus.IRin = 1'b1; tick(); bus.wr_en = 1'b0; bus.IRin = 1'b0;
      chk("s3_pp_T", bus.T, 1);
      chk_exec("s3_pp_data");
      chk("s3_pp_full", bus.full, 1);
      chk("s3_pp_ovf", bus.ovf, 0);
      bus.Clr = 1'b1; tick(); bus.Clr = 1'b0;
      n = 1;
      for (int k = 0; k < 2 * DEPTH && !bus.empty; k++) begin
         bus.IRin = 1'b1; tick(); bus.IRin = 1'b0;
         chk("s3_drain_T", bus.T, 1);
         chk_exec("s3_drain_data");
         bus.Clr = 1'b1; tick(); bus.Clr = 1'b0;
         n++;
      end
      chk("s3_exec_count", n, DEPTH + 1);
      chk("s3_empty", bus.empty, 1);
      chk("s3_queue_left", exp_q.size(), 0);

      // illegal word discarded, following word executes with IRin held
      push(10'h00F, 0); tick(); push(10'h013, 1); tick(); bus.wr_en = 1'b0;
      chk("s4_head_bad", bus.DATA, 10'h00F);
      bus.IRin = 1'b1; tick();
      chk("s4_T_stays0", bus.T, 0);
      chk("s4_illegal", bus.illegal, 1);
      chk("s4_head_next", bus.DATA, 10'h013);
      tick(); bus.IRin = 1'b0;
      chk("s4_T1", bus.T, 1);
      chk("s4_illegal_once", bus.illegal, 0);
      chk_exec("s4_exec_data");
      bus.Clr = 1'b1; tick(); bus.Clr = 1'b0;
      chk("s4_empty", bus.empty, 1);

      // no Clr: T wraps and timeout pulses
      push(10'h300, 1); tick(); bus.wr_en = 1'b0; tick();
      bus.IRin = 1'b1; tick(); bus.IRin = 1'b0;
      chk("s5_T1", bus.T, 1);
      chk_exec("s5_exec_data");
      tick(); chk("s5_T2", bus.T, 2);
      tick(); chk("s5_T3", bus.T, 3); chk("s5_timeout_pre", bus.timeout, 0);
      tick(); chk("s5_T0", bus.T, 0); chk("s5_timeout", bus.timeout, 1);
      tick(); chk("s5_timeout_once", bus.timeout, 0); chk("s5_empty", bus.empty, 1);

      // reset mid-EXEC with words queued
      for (int i = 1; i <= 4; i++) begin
         push(10'h200 + 10'(i), 1); tick();
      end
      bus.wr_en = 1'b0;
      bus.IRin = 1'b1; tick(); bus.IRin = 1'b0;
      chk("s6_T1", bus.T, 1);
      chk_exec("s6_exec_data");
      tick(); chk("s6_T2", bus.T, 2);
      rst = 1'b1; #1;
      chk("s6_rst_T", bus.T, 0);
      chk("s6_rst_DATA", bus.DATA, 0);
      chk("s6_rst_empty", bus.empty, 1);
      chk("s6_rst_full", bus.full, 0);
      exp_q.delete();
      tick(); rst = 1'b0;

      // after reset: IDLE behaviour, IRin in IDLE does not pop
      push(10'h205, 1); tick(); bus.wr_en = 1'b0;
      bus.IRin = 1'b1; tick();
      chk("s7_no_pop_T", bus.T, 0);
      chk("s7_no_pop_empty", bus.empty, 0);
      chk("s7_head", bus.DATA, 10'h205);
      tick(); bus.IRin = 1'b0;
      chk("s7_T1", bus.T, 1);
      chk_exec("s7_exec_data");
      bus.Clr = 1'b1; tick(); bus.Clr = 1'b0;
      chk("s7_empty", bus.empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
